// File: rtl/knight_rider_pkg.sv
// Shared constants and key-FSM state encoding for the knight_rider speed control.
package knight_rider_pkg;

  localparam int TAP_W       = 5;
  localparam int TAP_MIN     = 18;
  localparam int TAP_MAX     = 27;
  localparam int TAP_DEFAULT = 23;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    LOCK   = 2'd3
  } key_state_t;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser and debouncer for one active-low pushbutton, with
// registered one-cycle press (1->0) and release (0->1) pulses of the stable value.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic stable,
  output logic press,
  output logic rel
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic             stable_prev_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       fill_reg;
  logic             armed_reg;
  logic             press_reg;
  logic             rel_reg;

  // After reset a key must be seen released before it can debounce low, so a
  // hold that spans reset is ignored until the key is let go and pressed again.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_reg       <= 1'b1;
      sync2_reg       <= 1'b1;
      stable_reg      <= 1'b1;
      stable_prev_reg <= 1'b1;
      cnt_reg         <= '0;
      fill_reg        <= 2'd0;
      armed_reg       <= 1'b0;
      press_reg       <= 1'b0;
      rel_reg         <= 1'b0;
    end else begin
      sync1_reg       <= key;
      sync2_reg       <= sync1_reg;
      stable_prev_reg <= stable_reg;
      press_reg       <= stable_prev_reg & ~stable_reg;
      rel_reg         <= ~stable_prev_reg & stable_reg;
      if (fill_reg != 2'd2) fill_reg <= fill_reg + 2'd1;
      if (fill_reg == 2'd2 && sync2_reg) armed_reg <= 1'b1;
      if (!armed_reg || sync2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        stable_reg <= sync2_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign stable = stable_reg;
  assign press  = press_reg;
  assign rel    = rel_reg;

endmodule

// File: rtl/knight_rider_speed_ctrl.sv
// Turns debounced KEY presses into a saturating scan-speed tap with single-step,
// auto-repeat and a two-key chord that restores the default tap.
module knight_rider_speed_ctrl
  import knight_rider_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic        MAX10_CLK1_50,
  input  logic        rst,
  input  logic [1:0]  KEY,
  output logic [31:0] counter_tap,
  output logic        tap_change,
  output logic        at_limit
);

  localparam int TIMER_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam logic [TIMER_W-1:0] DELAY_LAST  = TIMER_W'(REPEAT_DELAY - 1);
  localparam logic [TIMER_W-1:0] PERIOD_LAST = TIMER_W'(REPEAT_PERIOD - 1);

  logic [1:0] stable;
  logic [1:0] press;
  logic [1:0] rel;
  logic [1:0] step;
  logic       chord;
  logic       both_released;

  assign chord         = ~stable[0] & ~stable[1];
  assign both_released =  stable[0] &  stable[1];

  // Index 0 steps faster (tap-1), index 1 steps slower (tap+1).
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
      key_state_t         state_reg, state_next;
      logic [TIMER_W-1:0] timer_reg, timer_next;
      logic               step_int;

      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk    (MAX10_CLK1_50),
        .rst    (rst),
        .key    (KEY[gi]),
        .stable (stable[gi]),
        .press  (press[gi]),
        .rel    (rel[gi])
      );

      always_comb begin
        state_next = state_reg;
        timer_next = '0;
        step_int   = 1'b0;
        if (chord) begin
          state_next = LOCK;
        end else begin
          case (state_reg)
            IDLE: begin
              if (press[gi]) begin
                step_int   = 1'b1;
                state_next = DELAY;
              end
            end
            DELAY: begin
              if (rel[gi]) begin
                state_next = IDLE;
              end else if (timer_reg == DELAY_LAST) begin
                step_int   = 1'b1;
                state_next = REPEAT;
              end else begin
                timer_next = timer_reg + 1'b1;
              end
            end
            REPEAT: begin
              if (rel[gi]) begin
                state_next = IDLE;
              end else if (timer_reg == PERIOD_LAST) begin
                step_int = 1'b1;
              end else begin
                timer_next = timer_reg + 1'b1;
              end
            end
            default: begin
              if (both_released) state_next = IDLE;
            end
          endcase
        end
      end

      always_ff @(posedge MAX10_CLK1_50) begin
        if (!rst) begin
          state_reg <= IDLE;
          timer_reg <= '0;
        end else begin
          state_reg <= state_next;
          timer_reg <= timer_next;
        end
      end

      assign step[gi] = step_int;
    end
  endgenerate

  logic [TAP_W-1:0] tap_reg, tap_next;
  logic             tap_change_reg;

  always_comb begin
    tap_next = tap_reg;
    if (chord) begin
      tap_next = TAP_W'(TAP_DEFAULT);
    end else if (step[1] && tap_reg < TAP_W'(TAP_MAX)) begin
      tap_next = tap_reg + 1'b1;
    end else if (step[0] && tap_reg > TAP_W'(TAP_MIN)) begin
      tap_next = tap_reg - 1'b1;
    end
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!rst) begin
      tap_reg        <= TAP_W'(TAP_DEFAULT);
      tap_change_reg <= 1'b0;
    end else begin
      tap_reg        <= tap_next;
      tap_change_reg <= (tap_next != tap_reg);
    end
  end

  assign counter_tap = {{(32 - TAP_W){1'b0}}, tap_reg};
  assign tap_change  = tap_change_reg;
  assign at_limit    = (tap_reg == TAP_W'(TAP_MIN)) || (tap_reg == TAP_W'(TAP_MAX));

endmodule

// File: tb/tb_knight_rider_speed_ctrl.sv
// Directed bench for knight_rider_speed_ctrl with short debounce/repeat timings.
module tb_knight_rider_speed_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  key;
  logic [31:0] counter_tap;
  logic        tap_change;
  logic        at_limit;

  int checks = 0;
  int errors = 0;
  int chg    = 0;

  always #5 clk = ~clk;

  knight_rider_speed_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8)
  ) dut (
    .MAX10_CLK1_50 (clk),
    .rst           (rst),
    .KEY           (key),
    .counter_tap   (counter_tap),
    .tap_change    (tap_change),
    .at_limit      (at_limit)
  );

  typedef struct {
    logic       rst_n;
    logic [1:0] key;
    int         cyc;
    int         exp_tap;
    int         exp_chg;
    logic       exp_lim;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (tap_change === 1'b1) chg++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    key = 2'b11;
    ticks(2);
    rst = 1'b1;
    ticks(4);
    chg = 0;
  endtask

  initial begin
    rst = 1'b0;
    key = 2'b11;
    @(negedge clk);

    // rst_n, KEY, cycles, expected tap, expected tap_change pulses, expected at_limit
    vecs.push_back('{1'b0, 2'b11,  2, 23, 0, 1'b0});
    vecs.push_back('{1'b1, 2'b11, 10, 23, 0, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 12, 24, 1, 1'b0});
    vecs.push_back('{1'b1, 2'b11, 20, 24, 0, 1'b0});
    vecs.push_back('{1'b0, 2'b11,  2, 23, 0, 1'b0});
    vecs.push_back('{1'b1, 2'b11, 10, 23, 0, 1'b0});
    for (int i = 0; i < 5; i++) begin
      vecs.push_back('{1'b1, 2'b10, 2, 23, 0, 1'b0});
      vecs.push_back('{1'b1, 2'b11, 2, 23, 0, 1'b0});
    end
    vecs.push_back('{1'b1, 2'b11, 10, 23, 0, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 80, 27, 4, 1'b1});
    vecs.push_back('{1'b1, 2'b11, 20, 27, 0, 1'b1});
    vecs.push_back('{1'b0, 2'b11,  2, 23, 0, 1'b0});
    vecs.push_back('{1'b1, 2'b11, 10, 23, 0, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 80, 18, 5, 1'b1});
    vecs.push_back('{1'b1, 2'b11, 20, 18, 0, 1'b1});

    foreach (vecs[v]) begin
      rst = vecs[v].rst_n;
      key = vecs[v].key;
      chg = 0;
      ticks(vecs[v].cyc);
      $display("vec %0d: rst=%0b key=%b cyc=%0d -> tap=%0d changes=%0d limit=%0b",
               v, vecs[v].rst_n, vecs[v].key, vecs[v].cyc, counter_tap, chg, at_limit);
      check($sformatf("vec%0d_tap", v), counter_tap, vecs[v].exp_tap);
      check($sformatf("vec%0d_changes", v), chg, vecs[v].exp_chg);
      check($sformatf("vec%0d_limit", v), {31'd0, at_limit}, {31'd0, vecs[v].exp_lim});
    end

    // Press latency: tap moves on the 8th edge after the first low sample.
    do_reset();
    key = 2'b01;
    ticks(7);
    check("latency_edge7_tap", counter_tap, 23);
    tick();
    check("latency_edge8_tap", counter_tap, 24);
    check("latency_edge8_pulse", {31'd0, tap_change}, 1);
    tick();
    check("latency_edge9_pulse", {31'd0, tap_change}, 0);
    key = 2'b11;
    ticks(20);
    $display("latency: tap=%0d", counter_tap);

    // Chord from tap 20 while KEY[0] is auto-repeating at the lower limit.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      key = 2'b10;
      ticks(10);
      key = 2'b11;
      ticks(12);
    end
    check("chord_setup_tap", counter_tap, 20);
    key = 2'b10;
    ticks(30);
    check("chord_hold_tap", counter_tap, 18);
    check("chord_hold_limit", {31'd0, at_limit}, 1);
    chg = 0;
    key = 2'b00;
    ticks(30);
    check("chord_tap", counter_tap, 23);
    check("chord_changes", chg, 1);
    key = 2'b10;
    ticks(20);
    check("chord_one_held_tap", counter_tap, 23);
    key = 2'b11;
    ticks(20);
    check("chord_released_changes", chg, 1);
    key = 2'b10;
    ticks(12);
    key = 2'b11;
    ticks(12);
    check("chord_after_press_tap", counter_tap, 22);
    $display("chord: tap=%0d changes=%0d", counter_tap, chg);

    // Reset while KEY[0] is in auto-repeat.
    do_reset();
    key = 2'b10;
    ticks(40);
    check("midhold_repeat_tap", counter_tap, 20);
    rst = 1'b0;
    tick();
    check("midhold_reset_tap", counter_tap, 23);
    check("midhold_reset_pulse", {31'd0, tap_change}, 0);
    rst = 1'b1;
    chg = 0;
    ticks(40);
    check("midhold_still_held_tap", counter_tap, 23);
    check("midhold_still_held_changes", chg, 0);
    key = 2'b11;
    ticks(15);
    check("midhold_release_changes", chg, 0);
    key = 2'b10;
    ticks(12);
    check("midhold_repress_tap", counter_tap, 22);
    key = 2'b11;
    ticks(10);
    $display("midhold: tap=%0d changes=%0d", counter_tap, chg);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/knight_rider_speed_ctrl.md
Name: knight_rider_speed_ctrl

Overview:
Upstream control stage for the knight_rider LED scanner on the DE10-Lite. Debounces the two raw pushbuttons (KEY[1:0]) and turns presses into a saturating scan-speed setting, driven out as counter_tap. counter_tap feeds the clock divider tap input of knight_rider. Supports single-step presses, auto-repeat while a key is held, and a two-key chord that restores the default speed.

Parameters:
DEBOUNCE_CYCLES, 500000, number of consecutive stable synchronised samples (10 ms at 50 MHz) required before a key state is accepted
REPEAT_DELAY, 25000000, cycles from the first step to the first auto-repeat step while a key is held
REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat steps
TAP_MIN, 18, lowest allowed tap (fastest scan)
TAP_MAX, 27, highest allowed tap (slowest scan)
TAP_DEFAULT, 23, tap value after reset and after a chord

Ports:
MAX10_CLK1_50  input  1  single system clock; all logic on its rising edge
rst  input  1  synchronous, active-low reset; rst==0 resets the block on the next rising edge
KEY  input  2  raw asynchronous pushbuttons, active-low; KEY[0]=faster (tap-1), KEY[1]=slower (tap+1)
counter_tap  output  32  current tap, zero-extended from 5 bits, for the clock divider
tap_change  output  1  one-cycle pulse, high in the first cycle counter_tap shows a new value
at_limit  output  1  high while counter_tap equals TAP_MIN or TAP_MAX

Behaviour:
- Reset state (rst==0 at a clock edge): counter_tap=TAP_DEFAULT, tap_change=0, at_limit=0 with default parameters. Synchronisers and debounced state are 1 (released). Debounce and repeat counters are 0. Both key FSMs are in IDLE, and the chord lock is clear. Reset mid-hold abandons the hold, and no step is issued on release.
- Synchroniser: two flops per key. Nothing downstream uses the raw KEY.
- Debounce, per key: while the synchronised value differs from the stable value, cnt increments. When cnt==DEBOUNCE_CYCLES-1 and the values still differ, stable takes the synchronised value and cnt clears. Any sample equal to stable clears cnt, so bounces shorter than DEBOUNCE_CYCLES are rejected.
- Press event: stable goes 1->0, registered into a one-cycle pulse.
- Release: stable goes 0->1. This returns the key FSM to IDLE immediately.
- Latency: a clean press changes counter_tap on the (DEBOUNCE_CYCLES+4)th rising edge after the first edge that samples KEY low.
- Per-key FSM states:
  - IDLE: on press, issue one step, clear the timer, and go to DELAY.
  - DELAY: the timer counts. At REPEAT_DELAY-1, issue a step, clear the timer, and go to REPEAT.
  - REPEAT: at REPEAT_PERIOD-1, issue a step and clear the timer.
  - Release in DELAY or REPEAT goes to IDLE with no step.
- Chord: if both stable values are 0 in the same cycle, the chord takes effect.
  - That cycle: counter_tap <= TAP_DEFAULT, no step from either FSM, both FSMs forced to LOCK.
  - LOCK: no steps are issued. Exit to IDLE only when both keys are stable-released.
  - A chord that starts while counter_tap already equals TAP_DEFAULT produces no tap_change.
- Step application: counter_tap updates on the edge after the step is issued.
  - tap+1 is applied only if tap<TAP_MAX; tap-1 only if tap>TAP_MIN.
  - A blocked step leaves counter_tap unchanged, with no tap_change.
  - Opposite steps in the same cycle cannot occur, because that condition is a chord.
- tap_change is registered: high for exactly one cycle whenever the registered tap value differs from its previous value.
- at_limit is combinational from the tap register.
- Width rules:
  - The tap register is 5 bits, and counter_tap[31:5] is always 0.
  - Timers are 25 bits wide, sized by $clog2 of the largest count.
  - Parameters must satisfy TAP_MIN<=TAP_DEFAULT<=TAP_MAX<=31.

Decomposition:
- Shared package (knight_rider_pkg): TAP_MIN, TAP_MAX, TAP_DEFAULT, the tap width (5), and the FSM state encoding (IDLE, DELAY, REPEAT, LOCK, 2 bits).
- One natural sub-module: key_debounce, containing the 2-flop synchroniser, debounce counter, stable output, and press/release pulses. It is instantiated twice. The FSMs, chord logic and tap register stay in the top module.

Test Plan:
(All scenarios use simulation parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8; tap defaults unchanged.)
- Reset: rst=0 for 2 cycles with KEY=2'b11, then rst=1 -> counter_tap=23, tap_change=0, at_limit=0 held indefinitely.
- Single press: KEY[1] low for 12 cycles, then high -> counter_tap=24 on edge 8 after the first low sample. tap_change high that single cycle. No further change.
- Bounce rejection: KEY[0] toggles low/high every 2 cycles for 20 cycles, then stays high -> counter_tap stays 23, tap_change never high.
- Auto-repeat and saturation: KEY[1] held low for 80 cycles -> steps at t, t+20, t+28, t+36, ... → counter_tap goes 24,25,26,27 and then stays 27. at_limit=1 from the step that reaches 27. No tap_change on blocked steps.
- Chord: from tap 20, hold KEY[0] for 30 cycles, then also press KEY[1] -> counter_tap=23 with one tap_change. No steps while either key remains held. After both keys are released, a single KEY[0] press gives 22.
- Reset mid-hold: KEY[0] held in REPEAT, rst=0 for 1 cycle -> counter_tap=23 next edge. Continued holding produces no step until the key is released and pressed again.
